// File: rtl/writeback_buffer.sv
// Writeback buffer: circular FIFO of pending {dst, data} register-file writes.
// Drains in acceptance order whenever the register file write port is free,
// and forwards the newest pending value for a queried register index.
module writeback_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_dst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       rf_busy,
    output logic                       writeEnable,
    output logic [ADDR_WIDTH-1:0]      dst,
    output logic [DATA_WIDTH-1:0]      dstWrite,
    input  logic [ADDR_WIDTH-1:0]      fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem_dst_q  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    // Handshake and drain strobes, derived from registered occupancy only
    always_comb begin
        in_ready    = (count_q != FULL);
        writeEnable = (count_q != '0) && !rf_busy;
        push        = in_valid && in_ready;
        pop         = writeEnable;
        dst         = mem_dst_q[head_q];
        dstWrite    = mem_data_q[head_q];
        count       = count_q;
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and pointer registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_dst_q[i]  <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                mem_dst_q[tail_q]  <= in_dst;
                mem_data_q[tail_q] <= in_data;
            end
        end
    end

    // Forwarding: scan pending entries oldest to newest so the newest match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (mem_dst_q[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_writeback_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 4;

    typedef struct {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_dst;
    logic [DW-1:0] in_data;
    logic          rf_busy;
    logic          writeEnable;
    logic [AW-1:0] dst;
    logic [DW-1:0] dstWrite;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [$clog2(DEPTH):0] count;

    entry_t model[$];
    bit     model_ok  = 1'b0;
    bit     head_zero = 1'b0;
    int     n_checks  = 0;
    int     n_pass    = 0;

    writeback_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dst      (in_dst),
        .in_data     (in_data),
        .rf_busy     (rf_busy),
        .writeEnable (writeEnable),
        .dst         (dst),
        .dstWrite    (dstWrite),
        .fwd_addr    (fwd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then
    // advance the model by what the buffer must do on the coming edge.
    task automatic step(input bit v, input logic [AW-1:0] d, input logic [DW-1:0] data,
                        input bit busy, input logic [AW-1:0] fa, input bit rst);
        bit            exp_rdy;
        bit            exp_we;
        bit            found;
        logic [DW-1:0] exp_fd;
        entry_t        e;
        @(negedge clk);
        rst_n    = ~rst;
        in_valid = v;
        in_dst   = d;
        in_data  = data;
        rf_busy  = busy;
        fwd_addr = fa;
        #1;
        exp_rdy = (model.size() != DEPTH);
        exp_we  = (model.size() != 0) && !busy;
        found   = 1'b0;
        exp_fd  = '0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (!found && model[i].d == fa) begin
                found  = 1'b1;
                exp_fd = model[i].v;
            end
        end
        if (model_ok) begin
            check("in_ready",    DW'(in_ready),    DW'(exp_rdy));
            check("writeEnable", DW'(writeEnable), DW'(exp_we));
            check("count",       DW'(count),       DW'(model.size()));
            check("fwd_hit",     DW'(fwd_hit),     DW'(found));
            check("fwd_data",    fwd_data,         exp_fd);
            if (model.size() != 0) begin
                check("dst",      DW'(dst), DW'(model[0].d));
                check("dstWrite", dstWrite, model[0].v);
            end else if (head_zero) begin
                check("dst_rst",      DW'(dst), '0);
                check("dstWrite_rst", dstWrite, '0);
            end
        end
        @(posedge clk);
        if (rst) begin
            model.delete();
            model_ok  = 1'b1;
            head_zero = 1'b1;
        end else begin
            if (exp_we) model.delete(0);
            if (v && exp_rdy) begin
                e.d = d;
                e.v = data;
                model.push_back(e);
                head_zero = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit busy, input logic [AW-1:0] fa);
        step(1'b0, '0, '0, busy, fa, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_dst   = '0;
        in_data  = '0;
        rf_busy  = 1'b0;
        fwd_addr = '0;

        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(1'b0, 4'd0);

        // Single push, one-cycle latency to the register file
        step(1'b1, 4'd3, 64'h1C8FBCBFB54D70F0, 1'b0, 4'd3, 1'b0);
        idle(1'b0, 4'd3);
        idle(1'b0, 4'd3);

        // Fill while blocked, extra push attempts while full, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, AW'(i), DW'(64'hA0 + i), 1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd9, 64'hBAD, 1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd7, 64'hB7, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0, 4'd7);

        // Newest matching entry wins forwarding; no-match reads zero
        step(1'b1, 4'd5, 64'h11, 1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd5, 64'h22, 1'b1, 4'd5, 1'b0);
        idle(1'b1, 4'd5);
        idle(1'b1, 4'd6);
        idle(1'b0, 4'd5);
        idle(1'b0, 4'd5);
        idle(1'b0, 4'd5);

        // Steady push+pop with two pending: pointers wrap, count holds
        step(1'b1, 4'd0, 64'hC0, 1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 64'hC1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, AW'(i + 2), DW'(64'hD0 + i), 1'b0, AW'(i), 1'b0);
        idle(1'b0, 4'd0);
        idle(1'b0, 4'd0);
        idle(1'b0, 4'd0);

        // Reset with pending entries discards them
        for (int i = 0; i < 3; i++) step(1'b1, AW'(i + 8), DW'(64'hE0 + i), 1'b1, 4'd8, 1'b0);
        step(1'b1, 4'd12, 64'hEE, 1'b0, 4'd8, 1'b1);
        idle(1'b0, 4'd8);
        idle(1'b0, 4'd9);
        idle(1'b0, 4'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60),
                 AW'($urandom_range(0, 5)),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 99) < 40),
                 AW'($urandom_range(0, 5)),
                 1'($urandom_range(0, 99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
